// File: rtl/bus_bridge_nch_pkg.sv
// Shared types and the default CPU/peripheral address map for the N-channel bus bridge.
package bus_bridge_nch_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StResp   = 2'd2
  } state_e;

  localparam logic [31:0] DramBase   = 32'h0000_0000;
  localparam logic [31:0] DramMask   = 32'hFFFF_C000;
  localparam logic [31:0] DigBase    = 32'hFFFF_F000;
  localparam logic [31:0] LedBase    = 32'hFFFF_F060;
  localparam logic [31:0] SwBase     = 32'hFFFF_F070;
  localparam logic [31:0] BtnBase    = 32'hFFFF_F078;
  localparam logic [31:0] PeriphMask = 32'hFFFF_FFFC;

  // Base bit set under an all-zero mask: the window can never match.
  localparam logic [31:0] NoHitBase  = 32'h0000_0001;
  localparam logic [31:0] NoHitMask  = 32'h0000_0000;

  localparam logic [6*32-1:0] DefSlvBase =
      {NoHitBase, BtnBase, LedBase, SwBase, DigBase, DramBase};
  localparam logic [6*32-1:0] DefSlvMask =
      {NoHitMask, PeriphMask, PeriphMask, PeriphMask, PeriphMask, DramMask};

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_bridge_nch_addr_decode.sv
// Combinational base/mask window decode; the lowest matching slot index wins.
module bus_bridge_nch_addr_decode #(
  parameter int unsigned N_SLV = 6,
  parameter int unsigned IDX_W = 3
) (
  input  logic [31:0]         addr,
  input  logic [32*N_SLV-1:0] base,
  input  logic [32*N_SLV-1:0] mask,
  output logic                hit,
  output logic [IDX_W-1:0]    idx
);

  always_comb begin
    hit = 1'b0;
    idx = '0;
    // Scan downwards so the last assignment is the lowest hitting slot.
    for (int i = int'(N_SLV) - 1; i >= 0; i--) begin
      if ((addr & mask[32*i +: 32]) == base[32*i +: 32]) begin
        hit = 1'b1;
        idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/bus_bridge_nch.sv
// CPU to N-slave bridge: one transaction at a time, ready handshake with timeout,
// registered read data and a bus-error flag.
module bus_bridge_nch
  import bus_bridge_nch_pkg::*;
#(
  parameter int unsigned         N_SLV    = 6,
  parameter int unsigned         DW       = 32,
  parameter logic [32*N_SLV-1:0] SLV_BASE = DefSlvBase,
  parameter logic [32*N_SLV-1:0] SLV_MASK = DefSlvMask,
  parameter int unsigned         TIMEOUT  = 15,
  parameter logic [DW-1:0]       ERR_DATA = '0
) (
  input  logic                cpu_clk,
  input  logic                cpu_rst_n,
  input  logic [31:0]         addr_from_cpu,
  input  logic                we_from_cpu,
  input  logic                re_from_cpu,
  input  logic [DW/8-1:0]     be_from_cpu,
  input  logic [DW-1:0]       wdata_from_cpu,
  output logic [DW-1:0]       rdata_to_cpu,
  output logic                ready_to_cpu,
  output logic                err_to_cpu,
  output logic [N_SLV-1:0]    sel_to_slv,
  output logic [31:0]         addr_to_slv,
  output logic                we_to_slv,
  output logic [DW/8-1:0]     be_to_slv,
  output logic [DW-1:0]       wdata_to_slv,
  input  logic [N_SLV*DW-1:0] rdata_from_slv,
  input  logic [N_SLV-1:0]    ready_from_slv
);

  localparam int unsigned IdxW = idx_width(N_SLV);
  localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CntW-1:0] CntMax  = CntW'(TIMEOUT);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [IdxW-1:0]     idx_q, idx_d, dec_idx;
  logic                miss_q, miss_d, wr_q, wr_d, dec_hit;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [N_SLV-1:0]    sel_q, sel_d;
  logic                we_slv_q, we_slv_d;
  logic [31:0]         addr_q, addr_d;
  logic [DW/8-1:0]     be_q, be_d;
  logic [DW-1:0]       wdata_q, wdata_d, rdata_q, rdata_d, slv_rdata;
  logic                ready_q, ready_d, err_q, err_d;
  logic                req, slv_ready, timed_out, done;

  bus_bridge_nch_addr_decode #(
    .N_SLV (N_SLV),
    .IDX_W (IdxW)
  ) u_decode (
    .addr (addr_from_cpu),
    .base (SLV_BASE),
    .mask (SLV_MASK),
    .hit  (dec_hit),
    .idx  (dec_idx)
  );

  assign req       = we_from_cpu | re_from_cpu;
  assign slv_ready = |(ready_from_slv & sel_q);
  assign slv_rdata = rdata_from_slv[int'(idx_q)*DW +: DW];
  assign timed_out = (TIMEOUT != 0) && (cnt_q == CntLast);
  // A decode miss spends one ACCESS cycle with nothing selected, so every
  // completion has the same two-cycle minimum latency.
  assign done      = slv_ready | miss_q | timed_out;

  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (req) state_d = StAccess;
      StAccess: if (done) state_d = StResp;
      StResp:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    idx_d    = idx_q;
    miss_d   = miss_q;
    wr_d     = wr_q;
    cnt_d    = cnt_q;
    sel_d    = sel_q;
    we_slv_d = we_slv_q;
    addr_d   = addr_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    rdata_d  = '0;
    ready_d  = 1'b0;
    err_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          idx_d  = dec_idx;
          miss_d = !dec_hit;
          wr_d   = we_from_cpu;
          cnt_d  = '0;
          if (dec_hit) begin
            sel_d          = '0;
            sel_d[dec_idx] = 1'b1;
            we_slv_d       = we_from_cpu;
            addr_d         = addr_from_cpu;
            be_d           = be_from_cpu;
            wdata_d        = wdata_from_cpu;
          end
        end
      end
      StAccess: begin
        if (cnt_q != CntMax) cnt_d = cnt_q + 1'b1;
        if (done) begin
          sel_d    = '0;
          we_slv_d = 1'b0;
          addr_d   = '0;
          be_d     = '0;
          wdata_d  = '0;
          ready_d  = 1'b1;
          if (slv_ready) begin
            rdata_d = wr_q ? '0 : slv_rdata;
          end else begin
            err_d   = 1'b1;
            rdata_d = ERR_DATA;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      idx_q    <= '0;
      miss_q   <= 1'b0;
      wr_q     <= 1'b0;
      cnt_q    <= '0;
      sel_q    <= '0;
      we_slv_q <= 1'b0;
      addr_q   <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      ready_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      idx_q    <= idx_d;
      miss_q   <= miss_d;
      wr_q     <= wr_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      we_slv_q <= we_slv_d;
      addr_q   <= addr_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      ready_q  <= ready_d;
      err_q    <= err_d;
    end
  end

  assign rdata_to_cpu = rdata_q;
  assign ready_to_cpu = ready_q;
  assign err_to_cpu   = err_q;
  assign sel_to_slv   = sel_q;
  assign addr_to_slv  = addr_q;
  assign we_to_slv    = we_slv_q;
  assign be_to_slv    = be_q;
  assign wdata_to_slv = wdata_q;

endmodule
